// File: rtl/led_pkg.sv
// rtl/led_pkg.sv - shared fader state encoding and default timing constants
package led_pkg;

    localparam int unsigned DEF_PWM_BITS = 8;
    localparam logic [31:0] DEF_STEP_DIV = 32'd390625;

    typedef enum logic [1:0] {
        OFF       = 2'd0,
        FADE_UP   = 2'd1,
        ON        = 2'd2,
        FADE_DOWN = 2'd3
    } fade_state_e;

    function automatic logic is_fading(input fade_state_e s);
        return (s == FADE_UP) || (s == FADE_DOWN);
    endfunction

endpackage

// File: rtl/led_pwm_core.sv
// rtl/led_pwm_core.sv - free-running PWM counter with period-aligned duty capture
module led_pwm_core
    import led_pkg::*;
#(
    parameter int unsigned PWM_BITS = DEF_PWM_BITS
) (
    input  logic                sys_clk,
    input  logic                sys_rst_n,
    input  logic [PWM_BITS-1:0] duty,
    output logic                led_pwm
);

    logic [PWM_BITS-1:0] pwm_cnt_q;
    logic [PWM_BITS-1:0] duty_q;
    logic [PWM_BITS-1:0] duty_cur;
    logic                led_pwm_q;

    // The new duty takes effect on the very cycle it is captured, so a
    // period is always compared against one single duty value.
    assign duty_cur = (pwm_cnt_q == '0) ? duty : duty_q;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            pwm_cnt_q <= '0;
            duty_q    <= '0;
            led_pwm_q <= 1'b0;
        end else begin
            pwm_cnt_q <= pwm_cnt_q + 1'b1;
            if (pwm_cnt_q == '0) begin
                duty_q <= duty;
            end
            led_pwm_q <= (pwm_cnt_q < duty_cur);
        end
    end

    assign led_pwm = led_pwm_q;

endmodule

// File: rtl/led_fader.sv
// rtl/led_fader.sv - LED fade FSM and PWM drive; LED_FADER_GAMMA_EN selects quadratic duty
module led_fader
    import led_pkg::*;
#(
    parameter int unsigned PWM_BITS = DEF_PWM_BITS,
    parameter logic [31:0] STEP_DIV = DEF_STEP_DIV
) (
    input  logic sys_clk,
    input  logic sys_rst_n,
    input  logic led_req,
    output logic led_pwm,
    output logic busy
);

    localparam logic [PWM_BITS-1:0] LEVEL_MAX = '1;
    localparam logic [PWM_BITS-1:0] LEVEL_ONE = PWM_BITS'(1);

    fade_state_e         state_q;
    logic [PWM_BITS-1:0] level_q;
    logic [31:0]         step_cnt_q;
    logic                busy_q;
    logic                step_tick;
    logic [PWM_BITS-1:0] duty;

    assign step_tick = is_fading(state_q) && (step_cnt_q == STEP_DIV - 32'd1);

    // Reversal is checked before step_tick so a direction change never moves
    // the level on the same edge, which keeps fast toggling jump-free.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q    <= OFF;
            level_q    <= '0;
            step_cnt_q <= '0;
            busy_q     <= 1'b0;
        end else begin
            case (state_q)
                OFF: begin
                    level_q <= '0;
                    if (led_req) begin
                        state_q    <= FADE_UP;
                        step_cnt_q <= '0;
                        busy_q     <= 1'b1;
                    end
                end
                FADE_UP: begin
                    if (!led_req) begin
                        state_q    <= FADE_DOWN;
                        step_cnt_q <= '0;
                        busy_q     <= 1'b1;
                    end else if (step_tick) begin
                        step_cnt_q <= '0;
                        if (level_q >= LEVEL_MAX - LEVEL_ONE) begin
                            level_q <= LEVEL_MAX;
                            state_q <= ON;
                            busy_q  <= 1'b0;
                        end else begin
                            level_q <= level_q + LEVEL_ONE;
                        end
                    end else begin
                        step_cnt_q <= step_cnt_q + 32'd1;
                    end
                end
                ON: begin
                    level_q <= LEVEL_MAX;
                    if (!led_req) begin
                        state_q    <= FADE_DOWN;
                        step_cnt_q <= '0;
                        busy_q     <= 1'b1;
                    end
                end
                FADE_DOWN: begin
                    if (led_req) begin
                        state_q    <= FADE_UP;
                        step_cnt_q <= '0;
                        busy_q     <= 1'b1;
                    end else if (step_tick) begin
                        step_cnt_q <= '0;
                        if (level_q <= LEVEL_ONE) begin
                            level_q <= '0;
                            state_q <= OFF;
                            busy_q  <= 1'b0;
                        end else begin
                            level_q <= level_q - LEVEL_ONE;
                        end
                    end else begin
                        step_cnt_q <= step_cnt_q + 32'd1;
                    end
                end
                default: begin
                    state_q    <= OFF;
                    level_q    <= '0;
                    step_cnt_q <= '0;
                    busy_q     <= 1'b0;
                end
            endcase
        end
    end

`ifdef LED_FADER_GAMMA_EN
    logic [2*PWM_BITS-1:0] level_w;
    logic [2*PWM_BITS-1:0] gamma_prod;

    // level*(level+1) keeps both endpoints exact after the shift.
    assign level_w    = {{PWM_BITS{1'b0}}, level_q};
    assign gamma_prod = level_w * (level_w + 1'b1);
    assign duty       = PWM_BITS'(gamma_prod >> PWM_BITS);
`else
    assign duty = level_q;
`endif

    led_pwm_core #(
        .PWM_BITS(PWM_BITS)
    ) u_pwm_core (
        .sys_clk  (sys_clk),
        .sys_rst_n(sys_rst_n),
        .duty     (duty),
        .led_pwm  (led_pwm)
    );

    assign busy = busy_q;

endmodule

// File: tb/tb_led_fader.sv
// tb/tb_led_fader.sv - directed table and corner sequences for led_fader (PWM_BITS=4, STEP_DIV=2)
module tb_led_fader;
    import led_pkg::*;

    localparam int          PB = 4;
    localparam logic [31:0] SD = 32'd2;

    logic sys_clk   = 1'b0;
    logic sys_rst_n = 1'b0;
    logic led_req   = 1'b0;
    logic led_pwm;
    logic busy;

    int errors = 0;
    int checks = 0;

    typedef struct {
        int          cyc;
        logic        req;
        int          lvl;
        fade_state_e st;
        logic        bsy;
        logic        meas;
    } vec_t;

    vec_t vecs[13];

    led_fader #(
        .PWM_BITS(PB),
        .STEP_DIV(SD)
    ) dut (
        .sys_clk  (sys_clk),
        .sys_rst_n(sys_rst_n),
        .led_req  (led_req),
        .led_pwm  (led_pwm),
        .busy     (busy)
    );

    always #5 sys_clk = ~sys_clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    function automatic int exp_duty(input int lvl);
`ifdef LED_FADER_GAMMA_EN
        return (lvl * (lvl + 1)) >> PB;
`else
        return lvl;
`endif
    endfunction

    // Leaves the bench one cycle before edge E1, which samples led_req = 1.
    task automatic reset_and_start();
        sys_rst_n = 1'b0;
        led_req   = 1'b1;
        ticks(2);
        sys_rst_n = 1'b1;
    endtask

    task automatic freeze(input int n);
        repeat (n) begin
            led_req = ~led_req;
            tick();
        end
    endtask

    task automatic measure_steady(input string name, input int d);
        int highs = 0;
        for (int i = 0; i < 16; i++) begin
            tick();
            if (led_pwm) highs++;
        end
        check(name, highs, d);
    endtask

    task automatic measure_toggle(input string name, input int lvl);
        int   highs  = 0;
        int   rises  = 0;
        int   first  = -1;
        int   second = -1;
        int   d;
        logic prev;
        prev = led_pwm;
        for (int i = 0; i < 32; i++) begin
            led_req = ~led_req;
            tick();
            if (led_pwm) highs++;
            if (led_pwm && !prev) begin
                rises++;
                if (first < 0) first = i;
                else if (second < 0) second = i;
            end
            prev = led_pwm;
        end
        d = exp_duty(lvl);
        check({name, "_highs"}, highs, 2 * d);
        if (d > 0 && d < (1 << PB)) begin
            check({name, "_rises"}, rises, 2);
            check({name, "_period"}, second - first, 16);
        end
        check({name, "_level"}, dut.level_q, lvl);
    endtask

    initial begin
        int found;

        vecs[0]  = '{1,  1'b1, 0,  FADE_UP,   1'b1, 1'b0};
        vecs[1]  = '{2,  1'b1, 1,  FADE_UP,   1'b1, 1'b0};
        vecs[2]  = '{8,  1'b1, 5,  FADE_UP,   1'b1, 1'b0};
        vecs[3]  = '{18, 1'b1, 14, FADE_UP,   1'b1, 1'b0};
        vecs[4]  = '{1,  1'b1, 14, FADE_UP,   1'b1, 1'b0};
        vecs[5]  = '{1,  1'b1, 15, ON,        1'b0, 1'b0};
        vecs[6]  = '{20, 1'b1, 15, ON,        1'b0, 1'b1};
        vecs[7]  = '{1,  1'b0, 15, FADE_DOWN, 1'b1, 1'b0};
        vecs[8]  = '{2,  1'b0, 14, FADE_DOWN, 1'b1, 1'b0};
        vecs[9]  = '{26, 1'b0, 1,  FADE_DOWN, 1'b1, 1'b0};
        vecs[10] = '{1,  1'b0, 1,  FADE_DOWN, 1'b1, 1'b0};
        vecs[11] = '{1,  1'b0, 0,  OFF,       1'b0, 1'b0};
        vecs[12] = '{20, 1'b0, 0,  OFF,       1'b0, 1'b1};

        // Reset held with led_req high
        sys_rst_n = 1'b0;
        led_req   = 1'b1;
        ticks(3);
        check("reset_pwm", led_pwm, 0);
        check("reset_busy", busy, 0);
        check("reset_state", 32'(dut.state_q), 32'(OFF));
        check("reset_level", dut.level_q, 0);
        sys_rst_n = 1'b1;

        for (int i = 0; i < 13; i++) begin
            led_req = vecs[i].req;
            ticks(vecs[i].cyc);
            check($sformatf("vec%0d_level", i), dut.level_q, vecs[i].lvl);
            check($sformatf("vec%0d_state", i), 32'(dut.state_q), 32'(vecs[i].st));
            check($sformatf("vec%0d_busy", i), busy, vecs[i].bsy);
            if (vecs[i].meas)
                measure_steady($sformatf("vec%0d_pwm_highs", i), exp_duty(vecs[i].lvl));
        end

        // Reversal at level 5 on a non-tick cycle, then full descent
        reset_and_start();
        ticks(11);
        check("rev_start_level", dut.level_q, 5);
        led_req = 1'b0;
        tick();
        check("rev_state", 32'(dut.state_q), 32'(FADE_DOWN));
        check("rev_hold_level", dut.level_q, 5);
        for (int k = 4; k >= 0; k--) begin
            tick();
            check($sformatf("rev_pre_%0d", k), dut.level_q, k + 1);
            tick();
            check($sformatf("rev_step_%0d", k), dut.level_q, k);
        end
        check("rev_end_state", 32'(dut.state_q), 32'(OFF));
        check("rev_end_busy", busy, 0);
        ticks(20);
        measure_steady("rev_off_pwm_highs", 0);

        // Reversal coinciding with step_tick: level must hold
        reset_and_start();
        ticks(12);
        led_req = 1'b0;
        tick();
        check("tickrev_level", dut.level_q, 5);
        check("tickrev_state", 32'(dut.state_q), 32'(FADE_DOWN));
        tick();
        check("tickrev_level2", dut.level_q, 5);
        tick();
        check("tickrev_level3", dut.level_q, 4);

        // Level frozen by toggling at 8 and at 4
        reset_and_start();
        ticks(17);
        check("freeze8_start", dut.level_q, 8);
        freeze(20);
        measure_toggle("freeze8", 8);

        reset_and_start();
        ticks(9);
        check("freeze4_start", dut.level_q, 4);
        freeze(20);
        measure_toggle("freeze4", 4);

        // Reset mid-fade at level 9 while led_pwm is high
        reset_and_start();
        ticks(19);
        check("midrst_start", dut.level_q, 9);
        freeze(20);
        found = 0;
        for (int i = 0; i < 20 && found == 0; i++) begin
            if (led_pwm) found = 1;
            else freeze(1);
        end
        check("midrst_pwm_high_seen", found, 1);
        #2;
        sys_rst_n = 1'b0;
        #1;
        check("midrst_pwm_low", led_pwm, 0);
        check("midrst_busy", busy, 0);
        check("midrst_state", 32'(dut.state_q), 32'(OFF));
        led_req = 1'b0;
        ticks(2);
        sys_rst_n = 1'b1;
        ticks(5);
        check("midrst_after_level", dut.level_q, 0);
        check("midrst_after_state", 32'(dut.state_q), 32'(OFF));
        check("midrst_after_busy", busy, 0);
        measure_steady("midrst_after_pwm_highs", 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
